// File: rtl/run_supervisor.sv
// Run controller for the f8 test system: sequences cpu reset, watches traps, done and a
// run-length watchdog, then latches a pass/fail verdict and freezes the system on halt.
module run_supervisor #(
    parameter int NUM_TRAPS      = 1,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 160,
    parameter int DRAIN_CYCLES   = 1,
    parameter int CNT_W          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_TRAPS-1:0]         trap,
    input  logic                         done,
    output logic                         cpu_reset,
    output logic                         halt,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   fail_cause,
    output logic [$clog2(NUM_TRAPS):0]   trap_id,
    output logic [CNT_W-1:0]             cycle_count
);

    localparam int ID_W   = $clog2(NUM_TRAPS) + 1;
    localparam int PH_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    // A timeout beyond the counter range could never be reached, so it disables the watchdog.
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0) &&
                           (longint'(TIMEOUT_CYCLES) <= (longint'(1) << CNT_W));
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [NUM_TRAPS-1:0] trap_q, trap_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 halt_q, halt_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic [1:0]           fail_cause_q, fail_cause_d;
    logic [ID_W-1:0]      trap_id_q, trap_id_d;

    logic [NUM_TRAPS-1:0] trap_evt;
    logic                 trap_any;
    logic [ID_W-1:0]      first_id;
    logic                 wd_hit;

    always_comb begin
        trap_evt = trap & ~trap_q;
        trap_any = |trap_evt;
        first_id = '0;
        for (int i = NUM_TRAPS - 1; i >= 0; i--) begin
            if (trap_evt[i]) first_id = ID_W'(i);
        end
        wd_hit = WD_EN && (cycle_count_q == WD_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_HOLD;
            phase_q       <= '0;
            trap_q        <= '0;
            cycle_count_q <= '0;
            cpu_reset_q   <= 1'b1;
            halt_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_cause_q  <= 2'd0;
            trap_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            trap_q        <= trap_d;
            cycle_count_q <= cycle_count_d;
            cpu_reset_q   <= cpu_reset_d;
            halt_q        <= halt_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            fail_cause_q  <= fail_cause_d;
            trap_id_q     <= trap_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD:   if (phase_q == HOLD_LAST) state_d = S_RUN;
            S_RUN: begin
                if (trap_any)    state_d = (DRAIN_CYCLES == 0) ? S_HALTED : S_DRAIN;
                else if (done)   state_d = S_HALTED;
                else if (wd_hit) state_d = S_HALTED;
            end
            S_DRAIN:  if (phase_q == DRAIN_LAST) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_HOLD;
        endcase
    end

    always_comb begin
        trap_d        = trap;
        phase_d       = phase_q;
        cycle_count_d = cycle_count_q;
        pass_d        = pass_q;
        fail_cause_d  = fail_cause_q;
        trap_id_d     = trap_id_q;
        case (state_q)
            S_HOLD:  phase_d = phase_q + PH_W'(1);
            S_RUN: begin
                // Phase is cleared here so DRAIN always starts counting from zero.
                phase_d = '0;
                if (trap_any) begin
                    fail_cause_d = 2'd1;
                    trap_id_d    = first_id;
                end else if (done) begin
                    pass_d = 1'b1;
                end else if (wd_hit) begin
                    fail_cause_d = 2'd2;
                end
            end
            S_DRAIN: phase_d = phase_q + PH_W'(1);
            default: phase_d = phase_q;
        endcase
        if (state_q == S_RUN || state_q == S_DRAIN) begin
            cycle_count_d = (cycle_count_q == {CNT_W{1'b1}}) ? cycle_count_q
                                                             : cycle_count_q + CNT_W'(1);
        end
        cpu_reset_d = (state_d == S_HOLD) || (state_d == S_HALTED);
        halt_d      = (state_d == S_HALTED);
        fail_d      = fail_q || ((state_d == S_HALTED) && (fail_cause_d != 2'd0));
    end

    assign cpu_reset   = cpu_reset_q;
    assign halt        = halt_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_cause  = fail_cause_q;
    assign trap_id     = trap_id_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_supervisor.sv
// Directed bench for run_supervisor: a vector table of complete runs plus hand-written
// sequences for drain timing, held traps, reset during drain and the disabled watchdog.
module tb_run_supervisor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, done_a;
    logic [3:0]  trap_a;
    logic        cpu_reset_a, halt_a, pass_a, fail_a;
    logic [1:0]  cause_a;
    logic [2:0]  id_a;
    logic [15:0] cnt_a;

    logic        rst_b, done_b;
    logic [0:0]  trap_b;
    logic        cpu_reset_b, halt_b, pass_b, fail_b;
    logic [1:0]  cause_b;
    logic [0:0]  id_b;
    logic [3:0]  cnt_b;

    run_supervisor #(.NUM_TRAPS(4), .RESET_CYCLES(2), .TIMEOUT_CYCLES(160),
                     .DRAIN_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a), .trap(trap_a), .done(done_a),
        .cpu_reset(cpu_reset_a), .halt(halt_a), .pass(pass_a), .fail(fail_a),
        .fail_cause(cause_a), .trap_id(id_a), .cycle_count(cnt_a));

    run_supervisor #(.NUM_TRAPS(1), .RESET_CYCLES(2), .TIMEOUT_CYCLES(0),
                     .DRAIN_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_b), .trap(trap_b), .done(done_b),
        .cpu_reset(cpu_reset_b), .halt(halt_b), .pass(pass_b), .fail(fail_b),
        .fail_cause(cause_b), .trap_id(id_b), .cycle_count(cnt_b));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          ev_cyc;
        logic [3:0]  trap_v;
        logic        done_v;
        logic        exp_pass;
        logic        exp_fail;
        logic [1:0]  exp_cause;
        logic [2:0]  exp_id;
        logic [15:0] exp_cnt;
        string       name;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [3:0] tinit, input string tag);
        rst_a  = 1'b0;
        trap_a = tinit;
        done_a = 1'b0;
        repeat (3) tick();
        rst_a = 1'b1;
        chk({tag, "_hold0_cpurst"}, 32'(cpu_reset_a), 32'd1);
        tick();
        chk({tag, "_hold1_cpurst"}, 32'(cpu_reset_a), 32'd1);
        tick();
        chk({tag, "_run_cpurst"}, 32'(cpu_reset_a), 32'd0);
        chk({tag, "_run_cnt0"}, 32'(cnt_a), 32'd0);
    endtask

    task automatic wait_halt_a(input string tag);
        int n = 0;
        while (halt_a !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_halt"}, 32'(halt_a), 32'd1);
    endtask

    initial begin
        vecs[0] = '{10, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 16'd11,  "done_c10"};
        vecs[1] = '{5,  4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, 3'd1, 16'd7,   "trap21_c5"};
        vecs[2] = '{3,  4'b0001, 1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 16'd5,   "trap0_done"};
        vecs[3] = '{0,  4'b1000, 1'b0, 1'b0, 1'b1, 2'd1, 3'd3, 16'd2,   "trap3_c0"};
        vecs[4] = '{-1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 16'd160, "timeout"};
        vecs[5] = '{0,  4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 16'd1,   "done_c0"};

        rst_a = 1'b1; trap_a = '0; done_a = 1'b0;
        rst_b = 1'b1; trap_b = '0; done_b = 1'b0;
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("rst_cpurst", 32'(cpu_reset_a), 32'd1);
        chk("rst_halt",   32'(halt_a),      32'd0);
        chk("rst_pass",   32'(pass_a),      32'd0);
        chk("rst_fail",   32'(fail_a),      32'd0);
        chk("rst_cause",  32'(cause_a),     32'd0);
        chk("rst_cnt",    32'(cnt_a),       32'd0);

        for (int v = 0; v < 6; v++) begin
            start_a(4'b0000, vecs[v].name);
            if (vecs[v].ev_cyc >= 0) begin
                repeat (vecs[v].ev_cyc) tick();
                trap_a = vecs[v].trap_v;
                done_a = vecs[v].done_v;
                tick();
                trap_a = '0;
                done_a = 1'b0;
            end
            wait_halt_a(vecs[v].name);
            chk({vecs[v].name, "_pass"},   32'(pass_a),      32'(vecs[v].exp_pass));
            chk({vecs[v].name, "_fail"},   32'(fail_a),      32'(vecs[v].exp_fail));
            chk({vecs[v].name, "_cause"},  32'(cause_a),     32'(vecs[v].exp_cause));
            chk({vecs[v].name, "_id"},     32'(id_a),        32'(vecs[v].exp_id));
            chk({vecs[v].name, "_cnt"},    32'(cnt_a),       32'(vecs[v].exp_cnt));
            chk({vecs[v].name, "_cpurst"}, 32'(cpu_reset_a), 32'd1);
            repeat (3) tick();
            chk({vecs[v].name, "_frozen"}, 32'(cnt_a),       32'(vecs[v].exp_cnt));
        end

        // Drain timing: verdict cause is visible one cycle before halt/fail.
        start_a(4'b0000, "drain");
        repeat (5) tick();
        trap_a = 4'b0110;
        tick();
        chk("drain_halt0",   32'(halt_a),      32'd0);
        chk("drain_fail0",   32'(fail_a),      32'd0);
        chk("drain_pass0",   32'(pass_a),      32'd0);
        chk("drain_cause",   32'(cause_a),     32'd1);
        chk("drain_id",      32'(id_a),        32'd1);
        chk("drain_cpurst",  32'(cpu_reset_a), 32'd0);
        chk("drain_cnt",     32'(cnt_a),       32'd6);
        tick();
        chk("drain_halt1",   32'(halt_a),      32'd1);
        chk("drain_fail1",   32'(fail_a),      32'd1);
        chk("drain_cnt_end", 32'(cnt_a),       32'd7);

        // Trap held through HOLD must not fire; then reset asynchronously during DRAIN.
        start_a(4'b0001, "held");
        repeat (20) tick();
        chk("held_halt", 32'(halt_a),  32'd0);
        chk("held_fail", 32'(fail_a),  32'd0);
        chk("held_cnt",  32'(cnt_a),   32'd20);
        trap_a = 4'b0000;
        tick();
        trap_a = 4'b0001;
        tick();
        chk("held_drain_cause", 32'(cause_a), 32'd1);
        chk("held_drain_halt",  32'(halt_a),  32'd0);
        #2;
        rst_a = 1'b0;
        #1;
        chk("arst_cpurst", 32'(cpu_reset_a), 32'd1);
        chk("arst_halt",   32'(halt_a),      32'd0);
        chk("arst_fail",   32'(fail_a),      32'd0);
        chk("arst_cause",  32'(cause_a),     32'd0);
        chk("arst_id",     32'(id_a),        32'd0);
        chk("arst_cnt",    32'(cnt_a),       32'd0);
        start_a(4'b0000, "fresh");
        repeat (2) tick();
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        chk("fresh_halt", 32'(halt_a), 32'd1);
        chk("fresh_pass", 32'(pass_a), 32'd1);
        chk("fresh_fail", 32'(fail_a), 32'd0);
        chk("fresh_cnt",  32'(cnt_a),  32'd3);

        // Watchdog disabled with a 4-bit counter: never halts, count saturates.
        rst_b = 1'b1;
        repeat (2) tick();
        chk("nowd_cpurst", 32'(cpu_reset_b), 32'd0);
        chk("nowd_cnt0",   32'(cnt_b),       32'd0);
        repeat (40) tick();
        chk("nowd_halt", 32'(halt_b), 32'd0);
        chk("nowd_fail", 32'(fail_b), 32'd0);
        chk("nowd_cnt",  32'(cnt_b),  32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
